// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like request/response responder.
// Request entries are stored whole in the request FIFO and decoded by the service FSM.
package sram_like_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int unsigned REQ_ENTRY_WD = 1 + 2 + 4 + 32 + 32;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_WAIT,
      RSP_ACCESS,
      RSP_RESP
   } rsp_state_e;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_entry_t;

   // Size is carried with each request but never used to shape the access.
   function automatic logic size_is_legal(logic [1:0] sz);
      return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
   endfunction

   function automatic logic [3:0] ram_we_of(logic wr, logic [3:0] wstrb);
      return wr ? wstrb : 4'b0000;
   endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// Request/response bundle between a pipeline-stage requester and the responder.
// The requester drives the request fields; the responder drives accept and response.
interface sram_like_responder_if;

   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req,
      output wr,
      output size,
      output wstrb,
      output addr,
      output wdata,
      input  addr_ok,
      input  data_ok,
      input  rdata
   );

   modport slave (
      input  req,
      input  wr,
      input  size,
      input  wstrb,
      input  addr,
      input  wdata,
      output addr_ok,
      output data_ok,
      output rdata
   );

endinterface

// File: rtl/req_fifo.sv
// In-order request queue. Push and pop are ignored when full/empty respectively;
// storage is unreset since only entries below count are ever observed.
module req_fifo
   import sram_like_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = REQ_ENTRY_WD
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q;
   logic [PtrW-1:0]  rptr_q;
   logic [PtrW:0]    count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CountFull);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop_ok) begin
            rptr_q <= rptr_q + 1'b1;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/sram_like_responder.sv
// Responder for the SRAM-like interface: queues up to DEPTH requests and serves them in
// order against an external 1-cycle synchronous RAM, one data_ok pulse per request.
module sram_like_responder
   import sram_like_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned RAM_AW = 12
) (
   input  logic                  clk,
   input  logic                  resetn,
   sram_like_responder_if.slave  bus,
   input  logic [3:0]            delay_cfg,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [RAM_AW-1:0]     ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   rsp_state_e      state_q;
   rsp_state_e      state_d;
   logic [3:0]      cnt_q;
   logic [3:0]      cnt_d;
   logic            resp_wr_q;
   logic            resp_wr_d;

   req_entry_t      push_entry;
   req_entry_t      head;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CntW-1:0] fifo_count;
   logic            unused_head;

   // No bypass: a full queue refuses even when the head is popped this cycle.
   assign bus.addr_ok = resetn && !fifo_full;
   assign push        = bus.req && bus.addr_ok;

   always_comb begin
      push_entry       = '0;
      push_entry.wr    = bus.wr;
      push_entry.size  = bus.size;
      push_entry.wstrb = bus.wstrb;
      push_entry.addr  = bus.addr;
      push_entry.wdata = bus.wdata;
   end

   req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REQ_ENTRY_WD)
   ) u_req_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .wdata  (push_entry),
      .pop    (pop),
      .rdata  (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= RSP_IDLE;
         cnt_q     <= '0;
         resp_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         resp_wr_q <= resp_wr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      resp_wr_d   = resp_wr_q;
      pop         = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 4'b0000;
      ram_addr    = '0;
      ram_wdata   = '0;
      bus.data_ok = 1'b0;
      bus.rdata   = '0;

      unique case (state_q)
         RSP_IDLE: begin
            // delay_cfg is sampled only here, so later changes never affect this request.
            if (!fifo_empty) begin
               if (delay_cfg == 4'd0) begin
                  state_d = RSP_ACCESS;
               end else begin
                  cnt_d   = delay_cfg;
                  state_d = RSP_WAIT;
               end
            end
         end
         RSP_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RSP_ACCESS;
            end
         end
         RSP_ACCESS: begin
            ram_en    = 1'b1;
            ram_we    = ram_we_of(head.wr, head.wstrb);
            ram_addr  = head.addr[RAM_AW+1:2];
            ram_wdata = head.wdata;
            pop       = 1'b1;
            resp_wr_d = head.wr;
            state_d   = RSP_RESP;
         end
         RSP_RESP: begin
            bus.data_ok = 1'b1;
            bus.rdata   = resp_wr_q ? 32'h0 : ram_rdata;
            state_d     = RSP_IDLE;
         end
         default: begin
            state_d = RSP_IDLE;
         end
      endcase
   end

   assign unused_head = ^{head.size, head.addr[31:RAM_AW+2], head.addr[1:0],
                          size_is_legal(head.size)};

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomized and directed bench for sram_like_responder, checked cycle by cycle against a
// schedule-based model of the in-order queue and a reference copy of the backing RAM.
module tb_sram_like_responder;
   import sram_like_pkg::*;

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned RAM_AW    = 12;
   localparam int unsigned MEM_WORDS = 64;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [3:0]        delay_cfg = 4'd0;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   sram_like_responder_if bus ();

   sram_like_responder #(
      .DEPTH  (DEPTH),
      .RAM_AW (RAM_AW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .delay_cfg (delay_cfg),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // Backing RAM: 1-cycle synchronous read, byte-enabled write.
   logic [31:0] ram_mem  [MEM_WORDS];
   logic [31:0] init_img [MEM_WORDS];
   logic        ram_load = 1'b0;

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < int'(MEM_WORDS); i++) ram_mem[i] <= init_img[i];
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram_mem[ram_addr[5:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         end
         ram_rdata <= ram_mem[ram_addr[5:0]];
      end
   end

   // Reference model: queue of accepted requests plus the access/response times of the head.
   typedef struct packed {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] ref_mem [MEM_WORDS];
   int          cyc = 0;
   bit          busy = 1'b0;
   int          acc_cyc = 0;
   int          rsp_cyc = 0;
   logic [31:0] rsp_data = '0;
   bit          pending = 1'b0;
   logic        e_addr_ok;
   logic [82:0] exp_vec;

   int checks = 0;
   int errors = 0;

   function automatic logic [82:0] obs_vec();
      return {bus.addr_ok, bus.data_ok, bus.rdata, ram_en, ram_we, ram_addr, ram_wdata};
   endfunction

   task automatic predict();
      logic              e_data_ok;
      logic [31:0]       e_rdata;
      logic              e_en;
      logic [3:0]        e_we;
      logic [RAM_AW-1:0] e_ra;
      logic [31:0]       e_wd;
      // A free server picks up the head: access after the latched delay, response one later.
      if (!busy && mq.size() != 0) begin
         busy    = 1'b1;
         acc_cyc = cyc + 1 + int'(delay_cfg);
         rsp_cyc = acc_cyc + 1;
      end
      e_addr_ok = (mq.size() < int'(DEPTH));
      e_data_ok = busy && (cyc == rsp_cyc);
      e_rdata   = e_data_ok ? rsp_data : 32'h0;
      e_en = 1'b0; e_we = '0; e_ra = '0; e_wd = '0;
      if (busy && cyc == acc_cyc) begin
         e_en = 1'b1;
         e_we = mq[0].wr ? mq[0].wstrb : 4'b0000;
         e_ra = mq[0].addr[RAM_AW+1:2];
         e_wd = mq[0].wdata;
      end
      exp_vec = {e_addr_ok, e_data_ok, e_rdata, e_en, e_we, e_ra, e_wd};
   endtask

   task automatic commit();
      mreq_t h;
      logic  accept;
      accept = bus.req && e_addr_ok;
      if (busy && cyc == acc_cyc) begin
         h = mq.pop_front();
         if (h.wr) begin
            for (int b = 0; b < 4; b++) begin
               if (h.wstrb[b]) ref_mem[h.addr[7:2]][b*8 +: 8] = h.wdata[b*8 +: 8];
            end
            rsp_data = 32'h0;
         end else begin
            rsp_data = ref_mem[h.addr[7:2]];
         end
      end
      if (busy && cyc == rsp_cyc) busy = 1'b0;
      if (accept) mq.push_back('{wr: bus.wr, wstrb: bus.wstrb, addr: bus.addr, wdata: bus.wdata});
      cyc++;
   endtask

   task automatic model_reset();
      mq.delete();
      busy    = 1'b0;
      pending = 1'b0;
   endtask

   task automatic step(input logic r, input logic w, input logic [3:0] strb,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] dly);
      if (pending) commit();
      @(negedge clk);
      bus.req   = r;
      bus.wr    = w;
      bus.size  = SZ_WORD;
      bus.wstrb = strb;
      bus.addr  = a;
      bus.wdata = d;
      delay_cfg = dly;
      #1;
      predict();
      pending = 1'b1;
   endtask

   task automatic step_idle(input logic [3:0] dly);
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, dly);
   endtask

   task automatic test_reset();
      bus.req = 1'b0; bus.wr = 1'b0; bus.size = '0; bus.wstrb = '0;
      bus.addr = '0; bus.wdata = '0;
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         init_img[i] = $urandom();
         ref_mem[i]  = init_img[i];
      end
      init_img[0] = 32'h02c00000; ref_mem[0] = 32'h02c00000;
      init_img[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
      ram_load = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ram_load = 1'b0;
      #1;
      if ({bus.addr_ok, bus.data_ok, bus.rdata, ram_en, ram_we} !== 39'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0",
                  {bus.addr_ok, bus.data_ok, bus.rdata, ram_en, ram_we});
      end
      checks++;
      if (dut.fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d want 0", dut.fifo_count);
      end
      checks++;
      resetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step_idle(4'd0);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL reset_release cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
      end
   endtask

   task automatic test_single_read();
      for (int k = 0; k < 5; k++) begin
         if (k == 0) step(1'b1, 1'b0, 4'h0, 32'h1c000000, 32'h0, 4'd0);
         else step_idle(4'd0);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL single_read cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
         if (k == 2) begin
            if (ram_en !== 1'b1 || ram_addr !== 12'h0) begin
               errors++;
               $display("FAIL single_read_access: ram_en %b addr %h want 1 000", ram_en, ram_addr);
            end
            checks++;
         end
         if (k == 3) begin
            if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h02c00000) begin
               errors++;
               $display("FAIL single_read_resp: data_ok %b rdata %h want 1 02c00000",
                        bus.data_ok, bus.rdata);
            end
            checks++;
         end
      end
   endtask

   task automatic test_full_fifo();
      int sent = 0;
      int fifth_cyc = -1;
      int n_resp = 0;
      for (int k = 0; k < 35; k++) begin
         if (sent < 5) step(1'b1, 1'b0, 4'h0, 32'h1c000000 + 32'(4 * (sent + 1)), 32'h0, 4'd2);
         else step_idle(4'd2);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL full_fifo cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
         if (bus.data_ok === 1'b1) n_resp++;
         if (sent < 5 && bus.addr_ok === 1'b1) begin
            if (sent == 4) fifth_cyc = k;
            sent++;
         end
      end
      if (fifth_cyc != 5) begin
         errors++;
         $display("FAIL full_fifo_fifth_accept: cycle %0d want 5", fifth_cyc);
      end
      checks++;
      if (n_resp != 5) begin
         errors++;
         $display("FAIL full_fifo_responses: got %0d want 5", n_resp);
      end
      checks++;
   endtask

   task automatic test_partial_write();
      logic [31:0] resp [2];
      logic [3:0]  first_we = 4'hf;
      bit          seen_en = 1'b0;
      int          n_resp = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) step(1'b1, 1'b1, 4'b0011, 32'h1c000010, 32'hdeadbeef, 4'd0);
         else if (k == 1) step(1'b1, 1'b0, 4'b0000, 32'h1c000010, 32'h0, 4'd0);
         else step_idle(4'd0);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL partial_write cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
         if (ram_en === 1'b1 && !seen_en) begin
            first_we = ram_we;
            seen_en  = 1'b1;
         end
         if (bus.data_ok === 1'b1) begin
            if (n_resp < 2) resp[n_resp] = bus.rdata;
            n_resp++;
         end
      end
      if (first_we !== 4'b0011) begin
         errors++;
         $display("FAIL partial_write_we: got %b want 0011", first_we);
      end
      checks++;
      if (n_resp != 2 || resp[0] !== 32'h0 || resp[1] !== 32'h1122beef) begin
         errors++;
         $display("FAIL partial_write_resp: n %0d rdata %h %h want 2 00000000 1122beef",
                  n_resp, resp[0], resp[1]);
      end
      checks++;
   endtask

   task automatic test_delay();
      int first = -1;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) step(1'b1, 1'b0, 4'h0, 32'h1c000008, 32'h0, 4'd3);
         else step_idle((k < 2) ? 4'd3 : 4'd0);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL delay cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
         if (bus.data_ok === 1'b1 && first < 0) first = k;
      end
      if (first != 6) begin
         errors++;
         $display("FAIL delay_latency: data_ok at cycle %0d want 6", first);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      int n_resp = 0;
      int first = -1;
      for (int k = 0; k < 4; k++) begin
         if (k < 2) step(1'b1, 1'b0, 4'h0, 32'h1c000020 + 32'(4 * k), 32'h0, 4'd0);
         else step_idle(4'd0);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL reset_mid_pre cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
      end
      #2 resetn = 1'b0;
      #1;
      if ({bus.addr_ok, bus.data_ok} !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_async: addr_ok,data_ok %b want 00", {bus.addr_ok, bus.data_ok});
      end
      checks++;
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step_idle(4'd0);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL reset_mid_quiet cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
         if (bus.data_ok === 1'b1) n_resp++;
      end
      if (n_resp != 0) begin
         errors++;
         $display("FAIL reset_mid_stale: %0d responses want 0", n_resp);
      end
      checks++;
      for (int k = 0; k < 6; k++) begin
         if (k == 0) step(1'b1, 1'b0, 4'h0, 32'h1c00000c, 32'h0, 4'd0);
         else step_idle(4'd0);
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL reset_mid_new cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
         if (bus.data_ok === 1'b1 && first < 0) first = k;
      end
      if (first != 3) begin
         errors++;
         $display("FAIL reset_mid_latency: data_ok at cycle %0d want 3", first);
      end
      checks++;
   endtask

   task automatic test_push_pop();
      for (int k = 0; k < 25; k++) begin
         if (k == 0 || k == 1 || k == 4) begin
            step(1'b1, 1'b0, 4'h0, 32'h1c000030 + 32'(4 * k), 32'h0, 4'd2);
         end else begin
            step_idle(4'd2);
         end
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL push_pop cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
         if (k == 4) begin
            if (ram_en !== 1'b1 || dut.fifo_count !== 3'd2) begin
               errors++;
               $display("FAIL push_pop_setup: ram_en %b count %0d want 1 2", ram_en, dut.fifo_count);
            end
            checks++;
         end
         if (k == 5) begin
            if (dut.fifo_count !== 3'd2) begin
               errors++;
               $display("FAIL push_pop_count: got %0d want 2", dut.fifo_count);
            end
            checks++;
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [5:0]  w6;
      for (int k = 0; k < 500; k++) begin
         r  = $urandom();
         w6 = 6'($urandom_range(0, 63));
         if (k < 420) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 {r[31:14], 6'b0, w6, r[1:0]}, $urandom(), 4'($urandom_range(0, 3)));
         end else begin
            step_idle(4'($urandom_range(0, 3)));
         end
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL random cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_full_fifo();
      test_partial_write();
      test_delay();
      test_reset_mid();
      test_push_pop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

endmodule
